// File: rtl/alu_seq_if.sv
// Operand/result bus for alu_seq: request side (operands, opcode) and
// response side (result, carry, product) each with a valid/ready pair.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   operand1;
  logic [WIDTH-1:0]   operand2;
  logic [3:0]         opcode;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   result;
  logic               carry_out;
  logic [2*WIDTH-1:0] product;
  logic               busy;

  // Issuing side (operand-fetch stage / writeback consumer).
  modport master (
    output in_valid, operand1, operand2, opcode, out_ready,
    input  in_ready, out_valid, result, carry_out, product, busy
  );

  // ALU side.
  modport slave (
    input  in_valid, operand1, operand2, opcode, out_ready,
    output in_ready, out_valid, result, carry_out, product, busy
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops register their result in one edge,
// MUL runs a WIDTH-iteration shift-add loop. One operation in flight.
module alu_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CntLast = SHW'(WIDTH - 1);
  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpAnd  = 4'd2;
  localparam logic [3:0] OpOr   = 4'd3;
  localparam logic [3:0] OpXor  = 4'd4;
  localparam logic [3:0] OpNot  = 4'd5;
  localparam logic [3:0] OpSll  = 4'd6;
  localparam logic [3:0] OpSrl  = 4'd7;
  localparam logic [3:0] OpSra  = 4'd8;
  localparam logic [3:0] OpSlt  = 4'd9;
  localparam logic [3:0] OpSltu = 4'd10;
  localparam logic [3:0] OpMul  = 4'd11;
  localparam logic [3:0] OpInc  = 4'd12;
  localparam logic [3:0] OpDec  = 4'd13;
  localparam logic [3:0] OpPass = 4'd14;
  localparam logic [3:0] OpNor  = 4'd15;

  typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 carry_q, carry_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  // Upper half accumulates partial sums; lower half holds the remaining
  // multiplier bits, shifted out LSB first.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [SHW-1:0]       cnt_q, cnt_d;

  logic [WIDTH-1:0]     alu_res;
  logic                 alu_cy;
  logic [WIDTH:0]       add_w, sub_w, inc_w, mul_add;
  logic [WIDTH-1:0]     dec_w;
  logic [SHW-1:0]       shamt;
  logic [2*WIDTH-1:0]   acc_next;
  logic                 accept;

  assign accept = (state_q == StIdle) && bus.in_valid;

  // Single-cycle ALU on the live inputs; captured only on an accept edge.
  always_comb begin
    add_w   = {1'b0, bus.operand1} + {1'b0, bus.operand2};
    sub_w   = {1'b0, bus.operand1} - {1'b0, bus.operand2};
    inc_w   = {1'b0, bus.operand1} + (WIDTH+1)'(1);
    dec_w   = bus.operand1 - WIDTH'(1);
    shamt   = bus.operand2[SHW-1:0];
    alu_res = '0;
    alu_cy  = 1'b0;
    unique case (bus.opcode)
      OpAdd: begin
        alu_res = add_w[WIDTH-1:0];
        alu_cy  = add_w[WIDTH];
      end
      OpSub: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_cy  = ~sub_w[WIDTH];  // no borrow
      end
      OpAnd:  alu_res = bus.operand1 & bus.operand2;
      OpOr:   alu_res = bus.operand1 | bus.operand2;
      OpXor:  alu_res = bus.operand1 ^ bus.operand2;
      OpNot:  alu_res = ~bus.operand1;
      OpSll:  alu_res = bus.operand1 << shamt;
      OpSrl:  alu_res = bus.operand1 >> shamt;
      OpSra:  alu_res = WIDTH'($signed(bus.operand1) >>> shamt);
      OpSlt:  alu_res = {{(WIDTH-1){1'b0}},
                         ($signed(bus.operand1) < $signed(bus.operand2))};
      OpSltu: alu_res = {{(WIDTH-1){1'b0}}, (bus.operand1 < bus.operand2)};
      OpMul:  alu_res = '0;
      OpInc: begin
        alu_res = inc_w[WIDTH-1:0];
        alu_cy  = inc_w[WIDTH];
      end
      OpDec: begin
        alu_res = dec_w;
        alu_cy  = (bus.operand1 != '0);
      end
      OpPass: alu_res = bus.operand2;
      OpNor:  alu_res = ~(bus.operand1 | bus.operand2);
      default: begin
        alu_res = '0;
        alu_cy  = 1'b0;
      end
    endcase
  end

  // One shift-add step: conditional WIDTH+1-bit add into the upper half, then shift right.
  always_comb begin
    mul_add  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    acc_next = {mul_add, acc_q[WIDTH-1:1]};
  end

  // Next-state and output-register logic.
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    carry_d   = carry_q;
    product_d = product_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (bus.opcode == OpMul) begin
            mcand_d   = bus.operand1;
            acc_d     = {{WIDTH{1'b0}}, bus.operand2};
            cnt_d     = '0;
            result_d  = '0;
            carry_d   = 1'b0;
            product_d = '0;
            state_d   = StMul;
          end else begin
            result_d  = alu_res;
            carry_d   = alu_cy;
            product_d = '0;
            state_d   = StDone;
          end
        end
      end
      StMul: begin
        acc_d = acc_next;
        cnt_d = cnt_q + SHW'(1);
        if (cnt_q == CntLast) begin
          result_d  = acc_next[WIDTH-1:0];
          product_d = acc_next;
          carry_d   = (acc_next[2*WIDTH-1:WIDTH] != '0);
          state_d   = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      result_q  <= '0;
      carry_q   <= 1'b0;
      product_q <= '0;
      mcand_q   <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      product_q <= product_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
    end
  end

  // Handshake and status outputs decode directly from the state register.
  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StDone);
    bus.busy      = (state_q == StMul);
    bus.result    = result_q;
    bus.carry_out = carry_q;
    bus.product   = product_q;
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a WIDTH=32 and a WIDTH=8 instance share clock and reset.
module tb_alu_seq;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  alu_seq_if #(.WIDTH(32)) if32 ();
  alu_seq_if #(.WIDTH(8))  if8 ();

  alu_seq #(.WIDTH(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(if32.slave));
  alu_seq #(.WIDTH(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          w8;
    logic [3:0]  opc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        cy;
    logic [63:0] prod;
    int          lat;
    int          busy_n;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input bit w8, input logic [3:0] opc, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input logic cy,
                         input logic [63:0] prod, input int lat, input int busy_n);
    vec_t v;
    v.w8 = w8; v.opc = opc; v.a = a; v.b = b; v.res = res; v.cy = cy;
    v.prod = prod; v.lat = lat; v.busy_n = busy_n;
    vecs.push_back(v);
  endtask

  // Issue one operation with out_ready=1 and observe it through the output handshake.
  task automatic do_op(input bit w8, input logic [3:0] opc, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] res, output logic cy,
                       output logic [63:0] prod, output int lat, output int busy_n,
                       output logic rdy_after, output logic ov_end, output logic rdy_end);
    logic ov, bz;
    @(negedge clk);
    if (w8) begin
      if8.in_valid = 1'b1; if8.operand1 = a[7:0]; if8.operand2 = b[7:0]; if8.opcode = opc;
    end else begin
      if32.in_valid = 1'b1; if32.operand1 = a; if32.operand2 = b; if32.opcode = opc;
    end
    @(posedge clk);
    #1;
    if8.in_valid  = 1'b0;
    if32.in_valid = 1'b0;
    rdy_after = w8 ? if8.in_ready : if32.in_ready;
    lat    = 1;
    busy_n = 0;
    ov = w8 ? if8.out_valid : if32.out_valid;
    bz = w8 ? if8.busy : if32.busy;
    while (!ov && lat < 200) begin
      if (bz) busy_n++;
      @(posedge clk);
      #1;
      lat++;
      ov = w8 ? if8.out_valid : if32.out_valid;
      bz = w8 ? if8.busy : if32.busy;
    end
    res  = w8 ? {24'd0, if8.result} : if32.result;
    cy   = w8 ? if8.carry_out : if32.carry_out;
    prod = w8 ? {48'd0, if8.product} : if32.product;
    @(posedge clk);
    #1;
    ov_end  = w8 ? if8.out_valid : if32.out_valid;
    rdy_end = w8 ? if8.in_ready : if32.in_ready;
  endtask

  initial begin
    logic [31:0] res;
    logic [63:0] prod;
    logic        cy, rdy_after, ov_end, rdy_end;
    int          lat, busy_n;
    string       tag;

    errors = 0;
    checks = 0;

    // WIDTH=32 opcode sweep, op1=op2=8.
    add_vec(0, 4'd0,  32'd8, 32'd8, 32'd16,         1'b0, 64'd0,  1,  0);
    add_vec(0, 4'd1,  32'd8, 32'd8, 32'd0,          1'b1, 64'd0,  1,  0);
    add_vec(0, 4'd2,  32'd8, 32'd8, 32'd8,          1'b0, 64'd0,  1,  0);
    add_vec(0, 4'd3,  32'd8, 32'd8, 32'd8,          1'b0, 64'd0,  1,  0);
    add_vec(0, 4'd4,  32'd8, 32'd8, 32'd0,          1'b0, 64'd0,  1,  0);
    add_vec(0, 4'd5,  32'd8, 32'd8, 32'hFFFF_FFF7,  1'b0, 64'd0,  1,  0);
    add_vec(0, 4'd6,  32'd8, 32'd8, 32'd2048,       1'b0, 64'd0,  1,  0);
    add_vec(0, 4'd7,  32'd8, 32'd8, 32'd0,          1'b0, 64'd0,  1,  0);
    add_vec(0, 4'd8,  32'd8, 32'd8, 32'd0,          1'b0, 64'd0,  1,  0);
    add_vec(0, 4'd9,  32'd8, 32'd8, 32'd0,          1'b0, 64'd0,  1,  0);
    add_vec(0, 4'd10, 32'd8, 32'd8, 32'd0,          1'b0, 64'd0,  1,  0);
    add_vec(0, 4'd11, 32'd8, 32'd8, 32'd64,         1'b0, 64'd64, 33, 32);
    add_vec(0, 4'd12, 32'd8, 32'd8, 32'd9,          1'b0, 64'd0,  1,  0);
    add_vec(0, 4'd13, 32'd8, 32'd8, 32'd7,          1'b1, 64'd0,  1,  0);
    add_vec(0, 4'd14, 32'd8, 32'd8, 32'd8,          1'b0, 64'd0,  1,  0);
    add_vec(0, 4'd15, 32'd8, 32'd8, 32'hFFFF_FFF7,  1'b0, 64'd0,  1,  0);
    // WIDTH=32 boundaries.
    add_vec(0, 4'd0,  32'hFFFF_FFFF, 32'd1, 32'd0,         1'b1, 64'd0, 1, 0);
    add_vec(0, 4'd1,  32'd0, 32'd1,         32'hFFFF_FFFF, 1'b0, 64'd0, 1, 0);
    add_vec(0, 4'd1,  32'd3, 32'd5,         32'hFFFF_FFFE, 1'b0, 64'd0, 1, 0);
    add_vec(0, 4'd8,  32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 64'd0, 1, 0);
    add_vec(0, 4'd7,  32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 64'd0, 1, 0);
    add_vec(0, 4'd6,  32'd5, 32'd32,        32'd5,         1'b0, 64'd0, 1, 0);
    add_vec(0, 4'd9,  32'hFFFF_FFFF, 32'd1, 32'd1,         1'b0, 64'd0, 1, 0);
    add_vec(0, 4'd10, 32'hFFFF_FFFF, 32'd1, 32'd0,         1'b0, 64'd0, 1, 0);
    add_vec(0, 4'd12, 32'hFFFF_FFFF, 32'd0, 32'd0,         1'b1, 64'd0, 1, 0);
    add_vec(0, 4'd13, 32'd0, 32'd0,         32'hFFFF_FFFF, 1'b0, 64'd0, 1, 0);
    add_vec(0, 4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b1,
            64'hFFFF_FFFE_0000_0001, 33, 32);
    add_vec(0, 4'd11, 32'd0, 32'd7,         32'd0,         1'b0, 64'd0, 33, 32);
    add_vec(0, 4'd11, 32'h0001_0000, 32'h0003_0000, 32'd0, 1'b1,
            64'h0000_0003_0000_0000, 33, 32);
    // WIDTH=8 instance.
    add_vec(1, 4'd11, 32'hFF, 32'hFF, 32'h01, 1'b1, 64'hFE01, 9, 8);
    add_vec(1, 4'd6,  32'h01, 32'd9,  32'h02, 1'b0, 64'd0,    1, 0);
    add_vec(1, 4'd0,  32'hFF, 32'h01, 32'h00, 1'b1, 64'd0,    1, 0);

    if32.in_valid = 1'b0; if32.operand1 = '0; if32.operand2 = '0; if32.opcode = '0;
    if32.out_ready = 1'b1;
    if8.in_valid = 1'b0; if8.operand1 = '0; if8.operand2 = '0; if8.opcode = '0;
    if8.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  {63'd0, if32.in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, if32.out_valid}, 64'd0);
    check("rst_busy",      {63'd0, if32.busy}, 64'd0);
    check("rst_result",    {32'd0, if32.result}, 64'd0);
    check("rst_carry",     {63'd0, if32.carry_out}, 64'd0);
    check("rst_product",   if32.product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].w8, vecs[i].opc, vecs[i].a, vecs[i].b, res, cy, prod, lat, busy_n,
            rdy_after, ov_end, rdy_end);
      tag = $sformatf("v%0d_op%0d_w%0d", i, vecs[i].opc, vecs[i].w8 ? 8 : 32);
      check({tag, "_result"},  {32'd0, res}, {32'd0, vecs[i].res});
      check({tag, "_carry"},   {63'd0, cy}, {63'd0, vecs[i].cy});
      check({tag, "_product"}, prod, vecs[i].prod);
      check({tag, "_latency"}, 64'(lat), 64'(vecs[i].lat));
      check({tag, "_busy"},    64'(busy_n), 64'(vecs[i].busy_n));
      check({tag, "_rdy_lo"},  {63'd0, rdy_after}, 64'd0);
      check({tag, "_ov_end"},  {63'd0, ov_end}, 64'd0);
      check({tag, "_rdy_end"}, {63'd0, rdy_end}, 64'd1);
    end

    // Back-pressure: hold result for 10 cycles while ignoring in_valid pulses.
    @(negedge clk);
    if32.out_ready = 1'b0;
    if32.in_valid = 1'b1; if32.operand1 = 32'd5; if32.operand2 = 32'd3; if32.opcode = 4'd0;
    @(posedge clk);
    #1;
    if32.in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check("bp_out_valid", {63'd0, if32.out_valid}, 64'd1);
      check("bp_result",    {32'd0, if32.result}, 64'd8);
      check("bp_in_ready",  {63'd0, if32.in_ready}, 64'd0);
      @(negedge clk);
      if32.in_valid = k[0];
      if32.operand1 = 32'd100 + k;
      if32.opcode   = 4'd14;
      @(posedge clk);
      #1;
    end
    if32.in_valid = 1'b0;
    check("bp_held_result", {32'd0, if32.result}, 64'd8);
    @(negedge clk);
    if32.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_ov", {63'd0, if32.out_valid}, 64'd0);
    @(posedge clk);
    #1;
    check("bp_single_result", {63'd0, if32.out_valid}, 64'd0);

    // Reset in the middle of a multiply.
    @(negedge clk);
    if32.in_valid = 1'b1; if32.operand1 = 32'd7; if32.operand2 = 32'd9; if32.opcode = 4'd11;
    @(posedge clk);
    #1;
    if32.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("mr_busy_mid", {63'd0, if32.busy}, 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mr_out_valid", {63'd0, if32.out_valid}, 64'd0);
    check("mr_busy",      {63'd0, if32.busy}, 64'd0);
    check("mr_product",   if32.product, 64'd0);
    check("mr_in_ready",  {63'd0, if32.in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(1'b0, 4'd0, 32'd2, 32'd2, res, cy, prod, lat, busy_n, rdy_after, ov_end, rdy_end);
    check("mr_add_result",  {32'd0, res}, 64'd4);
    check("mr_add_latency", 64'(lat), 64'd1);
    check("mr_add_product", prod, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, clocked successor to the combinational carry-select ALU (`alu1`).
- Same 16-opcode space (operand1/operand2/opcode -> result/carry_out/product), generalised to WIDTH bits.
- Registered outputs with valid/ready handshakes on input and output; iterative shift-add multiplier replaces the combinational product.
- Sits between the operand-fetch stage and writeback; one operation in flight at a time.

Parameters:
- WIDTH, 32: operand/result width (>=4, power of 2); product is 2*WIDTH.
- SHW, $clog2(WIDTH): shift-amount bits taken from operand2[SHW-1:0] (localparam, not overridable).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operands/opcode valid.
- in_ready  out  1  block can accept an operation.
- operand1  in  WIDTH  first operand.
- operand2  in  WIDTH  second operand / shift amount.
- opcode  in  4  operation select.
- out_valid  out  1  result/carry_out/product valid.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  ALU result.
- carry_out  out  1  carry/no-borrow flag.
- product  out  2*WIDTH  full multiply result.
- busy  out  1  high in MUL state.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; result, product, carry_out, out_valid, busy = 0; in_ready=1 next cycle. Reset mid-MUL or mid-DONE aborts the operation and discards its result.
- Accept: an operation is taken on a clk edge with in_valid && in_ready. Inputs are captured at that edge; later input changes are ignored.
- FSM IDLE:
  - in_ready=1.
  - Accept with opcode!=11: compute and register the outputs, go to DONE. out_valid rises 1 cycle after accept.
  - Accept with opcode==11: load multiplicand/multiplier, clear the accumulator, counter=0, go to MUL.
- FSM MUL:
  - in_ready=0, busy=1.
  - Each cycle: if multiplier LSB, add multiplicand (WIDTH+1-bit add) into the accumulator upper half; shift right by 1.
  - After exactly WIDTH iterations go to DONE. out_valid rises WIDTH+1 cycles after accept.
- FSM DONE:
  - in_ready=0; out_valid=1; outputs held stable.
  - Leaves on out_valid && out_ready and returns to IDLE. No new accept in that same cycle; next accept is possible 1 cycle later.
  - Back-pressure of any length holds all outputs unchanged.
- Opcodes (unsigned unless noted; results truncated to WIDTH):
  - 0 ADD: op1+op2; carry_out = bit WIDTH of the sum.
  - 1 SUB: op1-op2; carry_out = 1 if op1>=op2 (no borrow).
  - 2 AND. 3 OR. 4 XOR. 5 NOT op1. 15 NOR.
  - 6 SLL, 7 SRL, 8 SRA (arithmetic): op1 shifted by op2[SHW-1:0].
  - 9 SLT signed, 10 SLTU: result = {0..,1} or 0.
  - 11 MUL: product = op1*op2 (2*WIDTH bits); result = product[WIDTH-1:0]; carry_out = (product[2W-1:W] != 0).
  - 12 INC op1; carry_out = carry. 13 DEC op1; carry_out = 1 if op1!=0.
  - 14 PASS op2.
- Side-channel rules:
  - carry_out = 0 for opcodes other than 0, 1, 11, 12, 13.
  - product = 0 for every non-MUL opcode.
- Boundaries:
  - ADD/INC wrap to 0 with carry_out=1.
  - SUB 0-1 gives all-ones, carry_out=0.
  - Shift amount uses only SHW bits (shift by WIDTH behaves as shift by 0).
  - MUL with either operand 0 still takes WIDTH cycles.

Test Plan:
- WIDTH=32, op1=8, op2=8, sweep opcode 0..15 with out_ready=1 -> ADD=16, SUB=0 (carry 1), AND=8, OR=8, XOR=0, SLL=2048, SRL=0, SLT=0, MUL result=64/product=64 after 33 cycles, INC=9, DEC=7, PASS=8, NOR=0xFFFFFFF7. in_ready low only from accept until the out handshake.
- ADD 0xFFFFFFFF+1 -> result 0, carry_out 1. SUB 0-1 -> 0xFFFFFFFF, carry_out 0. SRA 0x80000000 by 4 -> 0xF8000000.
- MUL 0xFFFFFFFF*0xFFFFFFFF -> product 0xFFFFFFFE00000001, result 1, carry_out 1, out_valid exactly 33 cycles after accept, busy high 32 cycles.
- Back-pressure: out_ready=0 for 10 cycles after ADD 5+3 -> out_valid stays 1, result stays 8, in_ready stays 0; in_valid pulses ignored; single result on release.
- Reset mid-MUL: rst_n=0 for 1 cycle at iteration 10 -> next cycle out_valid=0, busy=0, product=0, in_ready=1; a fresh ADD 2+2 returns 4 with latency 1.
- WIDTH=8 instance: MUL 0xFF*0xFF -> product 0xFE01, latency 9; SLL by op2=9 -> shift by 1.
